// File: rtl/output_slice_scheduler.sv
// Merges per-slice 4-pixel group streams into one raster-order stream with
// frame/line markers and a single-stage valid/ready output register.
module output_slice_scheduler #(
   parameter int MAX_SLICE_WIDTH  = 2560,
   parameter int MAX_SLICES       = 4,
   parameter int MAX_FRAME_HEIGHT = 4096
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  flush,
   input  logic                                  start,
   input  logic [$clog2(MAX_SLICES+1)-1:0]       slices_per_line,
   input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]    slice_width,
   input  logic [$clog2(MAX_FRAME_HEIGHT+1)-1:0] frame_height,
   input  logic [MAX_SLICES-1:0]                 in_valid,
   input  logic [MAX_SLICES*168-1:0]             in_data,
   output logic [MAX_SLICES-1:0]                 in_ready,
   output logic [167:0]                          out_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  out_sof,
   output logic                                  out_sol,
   output logic                                  out_eol,
   output logic                                  out_eof,
   output logic                                  busy
);
   localparam int SPW = $clog2(MAX_SLICES+1);
   localparam int SWW = $clog2(MAX_SLICE_WIDTH);
   localparam int FHW = $clog2(MAX_FRAME_HEIGHT+1);
   localparam int GW  = SWW - 2;
   localparam int SIW = (MAX_SLICES > 1) ? $clog2(MAX_SLICES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                         state_q, state_d;
   logic [SPW-1:0]                 spl_q, spl_d, spl_cfg;
   logic [GW-1:0]                  g_q, g_d, g_cfg;
   logic [FHW-1:0]                 fh_q, fh_d, fh_cfg;
   logic [GW-1:0]                  grp_cnt_q, grp_cnt_d;
   logic [SIW-1:0]                 slice_idx_q, slice_idx_d;
   logic [FHW-1:0]                 line_cnt_q, line_cnt_d;
   logic                           first_grp_q, first_grp_d;
   logic [167:0]                   out_data_q, out_data_d;
   logic                           out_valid_q, out_valid_d;
   logic                           sof_q, sof_d, sol_q, sol_d, eol_q, eol_d, eof_q, eof_d;
   logic [MAX_SLICES-1:0][167:0]   in_grp;
   logic [SPW-1:0]                 slice_ext;
   logic                           load, grp_last, slc_last, line_last, frame_last;

   assign in_grp = in_data;

   // Degenerate configs are clamped so the wrap comparisons always terminate.
   always_comb begin
      spl_cfg = slices_per_line;
      if (slices_per_line == '0)
         spl_cfg = SPW'(1);
      else if (slices_per_line > SPW'(MAX_SLICES))
         spl_cfg = SPW'(MAX_SLICES);
      g_cfg  = (slice_width[SWW-1:2] == '0) ? GW'(1) : slice_width[SWW-1:2];
      fh_cfg = (frame_height == '0) ? FHW'(1) : frame_height;
   end

   always_comb begin
      slice_ext  = SPW'(slice_idx_q);
      grp_last   = (grp_cnt_q == g_q - GW'(1));
      slc_last   = (slice_ext == spl_q - SPW'(1));
      line_last  = (line_cnt_q == fh_q - FHW'(1));
      frame_last = grp_last & slc_last & line_last;
      load       = (state_q == RUN) & in_valid[slice_idx_q] & (~out_valid_q | out_ready) & ~flush;
      in_ready   = '0;
      if (load)
         in_ready[slice_idx_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush)
         state_d = IDLE;
      else begin
         case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (load && frame_last) state_d = DRAIN;
            DRAIN:   if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q != IDLE);
   end

   always_comb begin
      spl_d       = spl_q;
      g_d         = g_q;
      fh_d        = fh_q;
      grp_cnt_d   = grp_cnt_q;
      slice_idx_d = slice_idx_q;
      line_cnt_d  = line_cnt_q;
      first_grp_d = first_grp_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      sof_d       = sof_q;
      sol_d       = sol_q;
      eol_d       = eol_q;
      eof_d       = eof_q;
      if (flush) begin
         grp_cnt_d   = '0;
         slice_idx_d = '0;
         line_cnt_d  = '0;
         first_grp_d = 1'b0;
         out_valid_d = 1'b0;
         {sof_d, sol_d, eol_d, eof_d} = '0;
      end else begin
         if (state_q == IDLE && start) begin
            spl_d       = spl_cfg;
            g_d         = g_cfg;
            fh_d        = fh_cfg;
            grp_cnt_d   = '0;
            slice_idx_d = '0;
            line_cnt_d  = '0;
            first_grp_d = 1'b1;
         end
         if (load) begin
            out_data_d  = in_grp[slice_idx_q];
            out_valid_d = 1'b1;
            sof_d       = first_grp_q;
            sol_d       = (grp_cnt_q == '0) && (slice_idx_q == '0);
            eol_d       = grp_last & slc_last;
            eof_d       = grp_last & slc_last & line_last;
            first_grp_d = 1'b0;
            if (!grp_last)
               grp_cnt_d = grp_cnt_q + GW'(1);
            else begin
               grp_cnt_d = '0;
               if (!slc_last)
                  slice_idx_d = slice_idx_q + SIW'(1);
               else begin
                  slice_idx_d = '0;
                  line_cnt_d  = line_last ? '0 : line_cnt_q + FHW'(1);
               end
            end
         end else if (out_ready) begin
            // Markers drop with valid so a stale sof never reappears on an idle bus.
            out_valid_d = 1'b0;
            {sof_d, sol_d, eol_d, eof_d} = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spl_q       <= SPW'(1);
         g_q         <= GW'(1);
         fh_q        <= FHW'(1);
         grp_cnt_q   <= '0;
         slice_idx_q <= '0;
         line_cnt_q  <= '0;
         first_grp_q <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         sof_q       <= 1'b0;
         sol_q       <= 1'b0;
         eol_q       <= 1'b0;
         eof_q       <= 1'b0;
      end else begin
         spl_q       <= spl_d;
         g_q         <= g_d;
         fh_q        <= fh_d;
         grp_cnt_q   <= grp_cnt_d;
         slice_idx_q <= slice_idx_d;
         line_cnt_q  <= line_cnt_d;
         first_grp_q <= first_grp_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         sof_q       <= sof_d;
         sol_q       <= sol_d;
         eol_q       <= eol_d;
         eof_q       <= eof_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_sof   = sof_q;
   assign out_sol   = sol_q;
   assign out_eol   = eol_q;
   assign out_eof   = eof_q;

endmodule

// File: tb/tb_output_slice_scheduler.sv
// Directed bench: per-slice counting sources feed the scheduler; a raster-order
// scoreboard derived from the frame config checks every presented group.
module tb_output_slice_scheduler;
   logic          clk = 1'b0;
   logic          rst_n, flush, start;
   logic [2:0]    slices_per_line;
   logic [11:0]   slice_width;
   logic [12:0]   frame_height;
   logic [3:0]    in_valid;
   logic [671:0]  in_data;
   logic [3:0]    in_ready;
   logic [167:0]  out_data;
   logic          out_valid, out_ready, out_sof, out_sol, out_eol, out_eof, busy;
   logic [7:0]    pop_cnt [4];
   logic          pop_clr;
   int            total = 0;
   int            bad   = 0;

   always #5 clk = ~clk;

   output_slice_scheduler dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .start(start),
      .slices_per_line(slices_per_line), .slice_width(slice_width),
      .frame_height(frame_height), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_sof(out_sof), .out_sol(out_sol),
      .out_eol(out_eol), .out_eof(out_eof), .busy(busy)
   );

   function automatic logic [167:0] mk(input int s, input logic [7:0] p);
      logic [7:0] sb;
      sb = 8'(s);
      return {{10{sb, p}}, p};
   endfunction

   // Each slice source presents its next group number; a pop advances it.
   always @(posedge clk) begin
      for (int s = 0; s < 4; s++)
         if (pop_clr) pop_cnt[s] <= 8'd0;
         else if (in_ready[s]) pop_cnt[s] <= pop_cnt[s] + 8'd1;
   end

   always_comb begin
      in_data = '0;
      for (int s = 0; s < 4; s++)
         in_data[s*168 +: 168] = mk(s, pop_cnt[s]);
   end

   task automatic chk(input string tag, input logic [167:0] got, input logic [167:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic start_frame(input int spl, input int sw, input int fh);
      @(negedge clk);
      slices_per_line = 3'(spl); slice_width = 12'(sw); frame_height = 13'(fh);
      start = 1'b1; pop_clr = 1'b1;
      @(negedge clk);
      start = 1'b0; pop_clr = 1'b0;
   endtask

   // Runs one frame from a start in cycle 0; rdy_mode 1 toggles out_ready 1,0,1,0.
   task automatic run(input string nm, input int spl, input int sw, input int fh,
                      input int rdy_mode, input int st_lo, input int st_hi,
                      input int restart_c, input int exp_first, input int exp_last);
      int gi, per, tot, n, ln, r, sl, g, first, last, idle_c;
      bit done;
      gi = sw / 4; per = gi * spl; tot = per * fh;
      n = 0; first = -1; last = -1; idle_c = -1; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         start   = (c == 0) || (c == restart_c);
         pop_clr = (c == 0);
         if (c == 0) begin
            slices_per_line = 3'(spl); slice_width = 12'(sw); frame_height = 13'(fh);
         end
         if (c == restart_c) slice_width = 12'(sw * 2);
         out_ready = (rdy_mode == 0) ? 1'b1 : (c % 2 == 0);
         in_valid  = 4'hF;
         if (c >= st_lo && c <= st_hi) in_valid[1] = 1'b0;
         #1;
         if (!$onehot0(in_ready)) chk({nm, "_rdy_onehot"}, in_ready, 4'h0);
         if (out_valid && !out_ready) chk({nm, "_rdy_full"}, in_ready, 4'h0);
         if (out_valid) begin
            if (n < tot) begin
               ln = n / per; r = n % per; sl = r / gi; g = r % gi;
               chk({nm, "_data"}, out_data, mk(sl, 8'(ln * gi + g)));
               chk({nm, "_mark"}, {out_sof, out_sol, out_eol, out_eof},
                   {n == 0, r == 0, r == per - 1, n == tot - 1});
               if (first < 0) first = c;
               if (out_ready) begin
                  if (n == tot - 1) chk({nm, "_busy_last"}, busy, 1'b1);
                  last = c;
                  n++;
               end
            end else chk({nm, "_extra_grp"}, 1'b1, 1'b0);
         end
         if (n == tot && !busy) begin
            idle_c = c;
            done   = 1'b1;
         end
      end
      start = 1'b0; pop_clr = 1'b0;
      chk({nm, "_count"}, n, tot);
      chk({nm, "_idle_cyc"}, idle_c, last + 1);
      chk({nm, "_first"}, first, exp_first);
      chk({nm, "_last"}, last, exp_last);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; start = 1'b0; pop_clr = 1'b1;
      slices_per_line = 3'd2; slice_width = 12'd8; frame_height = 13'd2;
      in_valid = 4'hF; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_ready", in_ready, 4'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_data", out_data, '0);
      chk("rst_mark", {out_sof, out_sol, out_eol, out_eof}, 4'h0);
      @(negedge clk);
      rst_n = 1'b1; pop_clr = 1'b0;

      run("basic",   2, 8, 2, 0, -1, -1, -1, 2, 9);
      run("toggle",  2, 8, 2, 1, -1, -1, -1, 2, 16);
      run("stall",   2, 8, 2, 0,  3,  7, -1, 2, 14);

      // Flush while a group sits in the output register.
      start_frame(2, 8, 2);
      @(negedge clk);
      #1;
      chk("fl_pre_valid", out_valid, 1'b1);
      flush = 1'b1;
      #1;
      chk("fl_in_ready", in_ready, 4'h0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("fl_valid", out_valid, 1'b0);
      chk("fl_busy", busy, 1'b0);

      run("g1x4",    4, 4, 1, 0, -1, -1, -1, 2, 5);
      run("restart", 2, 8, 2, 0, -1, -1,  3, 2, 9);

      // Asynchronous reset mid-frame, asserted between clock edges.
      start_frame(1, 8, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_data", out_data, '0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
